// File: rtl/rtc_pkg.sv
// Shared constants for the rtc_time_core timekeeping slice.
// Field-select encoding for the adjust interface and the hour modulus.
package rtc_pkg;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_SEC  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_HOUR = 2'd3;

    localparam int HOUR_MOD = 24;

endpackage

// File: rtl/rtc_time_core_if.sv
// Control/status bundle between the tick/adjust logic, rtc_time_core and the display.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_time_core_if #(
    parameter int W = 6
);

    logic         tick;
    logic         run;
    logic         h24;
    logic [1:0]   sel;
    logic         inc;
    logic         dec;
    logic [W-1:0] sec;
    logic [W-1:0] min;
    logic [W-1:0] hour;
    logic         pm;
    logic         min_tick;
    logic         day_tick;

`ifdef RTC_ALARM_EN
    logic         alarm_set;
    logic         alarm_en;
    logic         alarm;

    modport master (
        output tick, run, h24, sel, inc, dec, alarm_set, alarm_en,
        input  sec, min, hour, pm, min_tick, day_tick, alarm
    );

    modport slave (
        input  tick, run, h24, sel, inc, dec, alarm_set, alarm_en,
        output sec, min, hour, pm, min_tick, day_tick, alarm
    );
`else
    modport master (
        output tick, run, h24, sel, inc, dec,
        input  sec, min, hour, pm, min_tick, day_tick
    );

    modport slave (
        input  tick, run, h24, sel, inc, dec,
        output sec, min, hour, pm, min_tick, day_tick
    );
`endif

endinterface

// File: rtl/rtc_mod_cnt.sv
// Modulo-MOD counter stage of the time carry chain: an adjust step wins over counting,
// and wrap only flags a counting wrap so adjusts never carry into the next field.
module rtc_mod_cnt #(
    parameter int MOD     = 60,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_inc,
    input  logic         adj_inc,
    input  logic         adj_dec,
    output logic [W-1:0] value,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);

    logic [W-1:0] r_value;
    logic         w_adjust;
    logic [W-1:0] w_incVal;
    logic [W-1:0] w_decVal;

    always_comb begin
        w_adjust = adj_inc ^ adj_dec;
        w_incVal = (r_value == MAX_VAL) ? '0 : r_value + W'(1);
        w_decVal = (r_value == '0) ? MAX_VAL : r_value - W'(1);
        wrap     = en_inc & ~w_adjust & (r_value == MAX_VAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_value <= W'(RST_VAL);
        else if (w_adjust)
            r_value <= adj_inc ? w_incVal : w_decVal;
        else if (en_inc)
            r_value <= w_incVal;
    end

    assign value = r_value;

endmodule

// File: rtl/rtc_time_core.sv
// Hours/minutes/seconds core: three modulo stages in a carry chain, field adjust,
// 12/24 h display mapping and registered carry pulses. RTC_ALARM_EN adds an alarm comparator.
module rtc_time_core
    import rtc_pkg::*;
#(
    parameter int W        = 6,
    parameter int SEC_MOD  = 60,
    parameter int MIN_MOD  = 60,
    parameter int RST_HOUR = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rtc_time_core_if.slave       bus
);

    logic         w_count;
    logic         w_incOnly;
    logic         w_decOnly;
    logic         w_secWrap;
    logic         w_minWrap;
    logic         w_hrWrap;
    logic [W-1:0] w_sec;
    logic [W-1:0] w_min;
    logic [W-1:0] w_hr;
    logic [W-1:0] w_hrMod12;
    logic         r_minTick;
    logic         r_dayTick;

    // inc and dec together cancel, so each stage sees at most one adjust direction
    assign w_count   = bus.tick & bus.run;
    assign w_incOnly = bus.inc & ~bus.dec;
    assign w_decOnly = bus.dec & ~bus.inc;

    rtc_mod_cnt #(.MOD(SEC_MOD), .W(W), .RST_VAL(0)) u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_inc  (w_count),
        .adj_inc (w_incOnly & (bus.sel == SEL_SEC)),
        .adj_dec (w_decOnly & (bus.sel == SEL_SEC)),
        .value   (w_sec),
        .wrap    (w_secWrap)
    );

    rtc_mod_cnt #(.MOD(MIN_MOD), .W(W), .RST_VAL(0)) u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_inc  (w_secWrap),
        .adj_inc (w_incOnly & (bus.sel == SEL_MIN)),
        .adj_dec (w_decOnly & (bus.sel == SEL_MIN)),
        .value   (w_min),
        .wrap    (w_minWrap)
    );

    rtc_mod_cnt #(.MOD(HOUR_MOD), .W(W), .RST_VAL(RST_HOUR)) u_hr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_inc  (w_minWrap),
        .adj_inc (w_incOnly & (bus.sel == SEL_HOUR)),
        .adj_dec (w_decOnly & (bus.sel == SEL_HOUR)),
        .value   (w_hr),
        .wrap    (w_hrWrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_minTick <= 1'b0;
            r_dayTick <= 1'b0;
        end else begin
            r_minTick <= w_secWrap;
            r_dayTick <= w_hrWrap;
        end
    end

    // 12 h mode shows midnight and noon as 12
    always_comb begin
        w_hrMod12 = (w_hr >= W'(12)) ? w_hr - W'(12) : w_hr;
        bus.hour  = bus.h24 ? w_hr : ((w_hrMod12 == '0) ? W'(12) : w_hrMod12);
        bus.pm    = (w_hr >= W'(12));
    end

    assign bus.sec      = w_sec;
    assign bus.min      = w_min;
    assign bus.min_tick = r_minTick;
    assign bus.day_tick = r_dayTick;

`ifdef RTC_ALARM_EN
    logic [W-1:0] r_alSec;
    logic [W-1:0] r_alMin;
    logic [W-1:0] r_alHr;
    logic         r_counted;

    // r_counted marks a cycle whose time came from a pure counting tick, not an adjust
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alSec   <= '0;
            r_alMin   <= '0;
            r_alHr    <= '0;
            r_counted <= 1'b0;
        end else begin
            if (bus.alarm_set) begin
                r_alSec <= w_sec;
                r_alMin <= w_min;
                r_alHr  <= w_hr;
            end
            r_counted <= w_count & ~((bus.inc ^ bus.dec) & (bus.sel != SEL_NONE));
        end
    end

    assign bus.alarm = r_counted & bus.alarm_en &
                       (w_sec == r_alSec) & (w_min == r_alMin) & (w_hr == r_alHr);
`endif

endmodule

// File: tb/tb_rtc_time_core.sv
// Directed self-checking bench for rtc_time_core; alarm checks compile in with RTC_ALARM_EN.
module tb_rtc_time_core;
    import rtc_pkg::*;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   passCount;
    int   pulseCount;
    int   alarmCount;
    int   base;

    rtc_time_core_if #(.W(6)) bus ();

    rtc_time_core #(.W(6), .SEC_MOD(60), .MIN_MOD(60), .RST_HOUR(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
        checkCount++;
        if (obs == exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // one clock of stimulus; returns at the following negedge with outputs settled
    task automatic applyStimulus(input logic tk, input logic [1:0] s, input logic up, input logic dn);
        @(negedge clk);
        bus.tick = tk;
        bus.sel  = s;
        bus.inc  = up;
        bus.dec  = dn;
        @(negedge clk);
        bus.tick = 1'b0;
        bus.sel  = SEL_NONE;
        bus.inc  = 1'b0;
        bus.dec  = 1'b0;
        pulseCount += int'(bus.min_tick) + int'(bus.day_tick);
`ifdef RTC_ALARM_EN
        alarmCount += int'(bus.alarm);
`endif
    endtask

    task automatic adjustField(input logic [1:0] s, input logic up, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, s, up, ~up);
    endtask

    task automatic checkTime(input string tag, input int h, input int m, input int s);
        checkOutput({tag, ".hour"}, bus.hour, h);
        checkOutput({tag, ".min"}, bus.min, m);
        checkOutput({tag, ".sec"}, bus.sec, s);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        pulseCount = 0;
        alarmCount = 0;
        rst_n    = 1'b0;
        bus.tick = 1'b0;
        bus.run  = 1'b0;
        bus.h24  = 1'b1;
        bus.sel  = SEL_NONE;
        bus.inc  = 1'b0;
        bus.dec  = 1'b0;
`ifdef RTC_ALARM_EN
        bus.alarm_set = 1'b0;
        bus.alarm_en  = 1'b1;
`endif
        repeat (2) @(negedge clk);
        checkTime("rst", 12, 0, 0);
        checkOutput("rst.pm", bus.pm, 1);
        checkOutput("rst.min_tick", bus.min_tick, 0);
        checkOutput("rst.day_tick", bus.day_tick, 0);
        rst_n = 1'b1;

        adjustField(SEL_HOUR, 1'b0, 7);
        adjustField(SEL_MIN, 1'b1, 10);
        adjustField(SEL_SEC, 1'b1, 20);
        checkTime("pre", 5, 10, 20);
        checkOutput("pre.pulses", pulseCount, 0);
        #2 rst_n = 1'b0;
        #1 checkTime("midrst", 12, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel.pm", bus.pm, 1);
        checkOutput("rel.hour24", bus.hour, 12);
        bus.h24 = 1'b0;
        #1 checkOutput("rel.hour12", bus.hour, 12);
        bus.h24 = 1'b1;

        adjustField(SEL_HOUR, 1'b1, 11);
        adjustField(SEL_MIN, 1'b0, 1);
        adjustField(SEL_SEC, 1'b0, 2);
        checkTime("preload", 23, 59, 58);
        checkOutput("preload.pulses", pulseCount, 0);
        bus.run = 1'b1;
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        checkTime("t1", 23, 59, 59);
        checkOutput("t1.min_tick", bus.min_tick, 0);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        checkTime("t2", 0, 0, 0);
        checkOutput("t2.min_tick", bus.min_tick, 1);
        checkOutput("t2.day_tick", bus.day_tick, 1);
        @(negedge clk);
        checkOutput("t3.min_tick", bus.min_tick, 0);
        checkOutput("t3.day_tick", bus.day_tick, 0);

        base = pulseCount;
        adjustField(SEL_HOUR, 1'b0, 25);
        checkTime("hrdec", 23, 0, 0);
        checkOutput("hrdec.pulses", pulseCount - base, 0);

        adjustField(SEL_MIN, 1'b1, 10);
        adjustField(SEL_SEC, 1'b0, 1);
        checkTime("coinc.pre", 23, 10, 59);
        applyStimulus(1'b1, SEL_MIN, 1'b1, 1'b0);
        checkTime("coinc", 23, 11, 0);
        checkOutput("coinc.min_tick", bus.min_tick, 1);
        checkOutput("coinc.day_tick", bus.day_tick, 0);

        adjustField(SEL_HOUR, 1'b1, 1);
        bus.h24 = 1'b0;
        #1 checkOutput("h12.hr0", bus.hour, 12);
        checkOutput("h12.pm0", bus.pm, 0);
        adjustField(SEL_HOUR, 1'b1, 13);
        checkOutput("h12.hr13", bus.hour, 1);
        checkOutput("h12.pm13", bus.pm, 1);
        bus.h24 = 1'b1;
        #1 checkOutput("h24.hr13", bus.hour, 13);

        adjustField(SEL_SEC, 1'b0, 1);
        applyStimulus(1'b1, SEL_SEC, 1'b1, 1'b0);
        checkTime("secadj", 13, 11, 0);
        checkOutput("secadj.min_tick", bus.min_tick, 0);
        applyStimulus(1'b0, SEL_MIN, 1'b1, 1'b1);
        checkOutput("incdec.min", bus.min, 11);
        applyStimulus(1'b0, SEL_NONE, 1'b1, 1'b0);
        checkTime("selnone", 13, 11, 0);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        checkOutput("tick.sec", bus.sec, 1);

`ifdef RTC_ALARM_EN
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        adjustField(SEL_HOUR, 1'b1, 12);
        adjustField(SEL_SEC, 1'b1, 5);
        checkTime("al.set", 0, 0, 5);
        @(negedge clk);
        bus.alarm_set = 1'b1;
        @(negedge clk);
        bus.alarm_set = 1'b0;
        base = alarmCount;
        adjustField(SEL_SEC, 1'b0, 2);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        checkOutput("al.fire", bus.alarm, 1);
        checkTime("al.time", 0, 0, 5);
        @(negedge clk);
        checkOutput("al.oneshot", bus.alarm, 0);
        checkOutput("al.count", alarmCount - base, 1);
        bus.alarm_en = 1'b0;
        base = alarmCount;
        adjustField(SEL_SEC, 1'b0, 2);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        applyStimulus(1'b1, SEL_NONE, 1'b0, 1'b0);
        checkOutput("al.disabled", alarmCount - base, 0);
        bus.alarm_en = 1'b1;
        base = alarmCount;
        adjustField(SEL_SEC, 1'b1, 1);
        adjustField(SEL_SEC, 1'b0, 1);
        checkOutput("al.adjust", alarmCount - base, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rtc_time_core.md
Name: rtc_time_core

Overview:
Parametrised hours/minutes/seconds timekeeping core for the clock design. It replaces the fixed 6-bit counter with a carry chain whose moduli are clean (no out-of-range transient states). It adds a field-select adjust interface, 12/24-hour display mode, carry/day pulses and an optional alarm comparator. It sits between the 1 Hz tick generator and the display/segment driver.

Parameters:
W, 6, width of sec/min/hour outputs (min 5; must hold SEC_MOD-1, MIN_MOD-1, 23)
SEC_MOD, 60, seconds modulus
MIN_MOD, 60, minutes modulus
RST_HOUR, 12, internal hour value after reset (0..23)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
tick  in  1  1-cycle 1 Hz enable pulse
run  in  1  1 = count on tick; 0 = hold (adjust still allowed)
h24  in  1  display mode: 1 = 24 h, 0 = 12 h
sel  in  2  adjust field: 0 none, 1 sec, 2 min, 3 hour
inc  in  1  1-cycle pulse, +1 on selected field
dec  in  1  1-cycle pulse, -1 on selected field
sec  out  W  seconds 0..SEC_MOD-1
min  out  W  minutes 0..MIN_MOD-1
hour  out  W  hour display value (24 h: 0..23; 12 h: 1..12)
pm  out  1  internal hour >= 12
min_tick  out  1  1-cycle pulse on seconds wrap
day_tick  out  1  1-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset: sec=0, min=0, internal hour=RST_HOUR, min_tick=0, day_tick=0; hour/pm derived from these.
- Internal hour hr is always 0..23. hour is combinational from hr: 24 h -> hr; 12 h -> (hr%12==0 ? 12 : hr%12). pm = (hr>=12). h24 changes take effect in the same cycle; counting is unaffected.
- Counting: on tick & run, sec increments. At SEC_MOD-1 it wraps to 0, min increments and min_tick=1 next cycle. Min wraps likewise into hr. At hr==23 with wrap, hr=0 and day_tick=1. All fields update in the same clock edge (1-cycle latency from tick).
- Values never leave range. No intermediate "60" state exists.
- Adjust: inc or dec with sel!=0 changes only the selected field by ±1 modulo its modulus. It produces no carry/borrow into other fields and no min_tick/day_tick.
- inc & dec together: no adjust. sel==0: inc/dec ignored.
- Simultaneous tick and adjust: the adjust has priority on the selected field, and that field does not advance this cycle. Lower fields still count normally. A carry into the adjusted field is dropped. Example: sel=min, inc, tick at sec=59 -> sec=0, min=+1 (the adjust only), min_tick=1.
- Adjusting sec while run=1 and tick coincident: sec takes the adjust value, and no min_tick is produced.
- rst_n asserted mid-operation: all state returns to reset values immediately (asynchronous); pulses are cleared.
- Pulse outputs are registered and high for exactly one cycle.

Optional Feature:
Macro RTC_ALARM_EN.
- When defined, it adds ports alarm_set (in, 1), alarm_en (in, 1) and alarm (out, 1).
- alarm_set=1 latches the current sec/min/hr into alarm registers; the alarm registers reset to 0.
- alarm pulses high for one cycle when a counting tick makes the time equal the stored alarm and alarm_en=1. Adjust-induced matches do not fire.
- When the macro is undefined, none of these ports or registers exist.

Decomposition:
- Package rtc_pkg holds the sel encoding constants (SEL_NONE, SEL_SEC, SEL_MIN, SEL_HOUR) and HOUR_MOD=24.
- One sub-module, rtc_mod_cnt, is a generic modulo counter with params MOD and W. Its inputs are en_inc, adj_inc, adj_dec. Its outputs are value and wrap, where wrap is asserted only on counting wrap. It is instantiated three times as the carry chain.

Test Plan:
- Reset mid-count at 05:10:20 -> outputs 12:00:00 immediately; after release, hr=12, pm=1, hour=12 in both modes.
- Preload 23:59:58 via adjust, then 2 ticks with run=1 -> 23:59:59, then 00:00:00; day_tick and min_tick each high exactly 1 cycle.
- sel=hour, 25 dec pulses from hr=0 -> hr=23 (wrap); min and sec unchanged; no pulses.
- sec=59, same cycle tick + sel=min + inc with min=10 -> sec=0, min=11 (not 12), min_tick=1.
- h24=0, hr=0 -> hour=12, pm=0; hr=13 -> hour=1, pm=1; toggle h24=1 -> hour=13.
- RTC_ALARM_EN: alarm_set at 00:00:05, then adjust to 00:00:03, run 2 ticks -> alarm pulses once at 00:00:05; with alarm_en=0 -> no pulse.
